// File: rtl/dfg_sink.sv
// Dataflow-graph edge sink: buffers R_IN/D_IN tokens in a FIFO for host readout, with sticky overflow flag.
// Optional running checksum of accepted words is enabled by defining DFG_SINK_CKSUM_EN.
module dfg_sink #(
    parameter int N     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          R_IN,
    input  logic [N-1:0]  D_IN,
    input  logic          RD,
    input  logic          CLR,
    output logic          R_OUT,
    output logic [N-1:0]  D_OUT,
    output logic          EMPTY,
    output logic          FULL,
    output logic [AW:0]   COUNT,
    output logic          OVF,
    output logic [N-1:0]  CKSUM
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          r_full;
    logic          r_ovf;
    logic          r_rout;
    logic [N-1:0]  r_dout;

    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_drop;
    logic [AW:0]   w_count_next;

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write alongside it.
    always_comb begin
        w_rd_acc     = EN & RD & ~r_empty;
        w_wr_acc     = EN & R_IN & (~r_full | w_rd_acc);
        w_drop       = EN & R_IN & r_full & ~w_rd_acc;
        w_count_next = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Data memory carries no reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= D_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_rout   <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_rout <= w_rd_acc;
            if (w_rd_acc) begin
                // On a full read+write the old word is read before the write overwrites the slot.
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CNT_FULL);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (EN && CLR) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef DFG_SINK_CKSUM_EN
    logic [N-1:0] r_cksum;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cksum <= '0;
        end else if (w_wr_acc) begin
            r_cksum <= r_cksum + D_IN;
        end
    end

    assign CKSUM = r_cksum;
`else
    assign CKSUM = '0;
`endif

    assign R_OUT = r_rout;
    assign D_OUT = r_dout;
    assign EMPTY = r_empty;
    assign FULL  = r_full;
    assign COUNT = r_count;
    assign OVF   = r_ovf;

endmodule

// File: tb/tb_dfg_sink.sv
// Scoreboard bench for dfg_sink: reads push expected words, a negedge monitor pops them on each R_OUT pulse.
module tb_dfg_sink;

    localparam int N = 16;
    localparam int DEPTH = 16;
    localparam int AW = 4;
`ifdef DFG_SINK_CKSUM_EN
    localparam bit CK_ON = 1'b1;
`else
    localparam bit CK_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          EN = 1'b0;
    logic          R_IN = 1'b0;
    logic [N-1:0]  D_IN = '0;
    logic          RD = 1'b0;
    logic          CLR = 1'b0;
    logic          R_OUT;
    logic [N-1:0]  D_OUT;
    logic          EMPTY;
    logic          FULL;
    logic [AW:0]   COUNT;
    logic          OVF;
    logic [N-1:0]  CKSUM;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [N-1:0]  exp_q[$];
    logic [N-1:0]  cksum_m = '0;

    dfg_sink #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .R_IN(R_IN), .D_IN(D_IN), .RD(RD), .CLR(CLR),
        .R_OUT(R_OUT), .D_OUT(D_OUT), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
        .OVF(OVF), .CKSUM(CKSUM)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every R_OUT pulse must match the oldest outstanding expected read.
    always @(negedge CLK) begin
        if (R_OUT === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_rout: got D_OUT %0h expected no pulse", D_OUT);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (D_OUT !== e) begin
                    n_errors++;
                    $display("FAIL read_data: got %0h expected %0h", D_OUT, e);
                end else begin
                    $display("read ok: D_OUT=%04h", D_OUT);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [N-1:0] v);
        R_IN = 1'b1;
        D_IN = v;
        cksum_m = cksum_m + v;
        step();
        R_IN = 1'b0;
        $display("write: D_IN=%04h COUNT=%0d", v, COUNT);
    endtask

    task automatic rd(input logic [N-1:0] v);
        RD = 1'b1;
        exp_q.push_back(v);
        step();
        RD = 1'b0;
        chk("rout_pulse", R_OUT, 1);
    endtask

    task automatic chk_ck(input string name);
        chk(name, CKSUM, CK_ON ? cksum_m : 16'h0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_rout", R_OUT, 0);
        chk("rst_dout", D_OUT, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_cksum", CKSUM, 0);
        RST = 1'b0;
        EN = 1'b1;

        // Basic write then read
        wr(16'd1); wr(16'd2); wr(16'd3);
        chk("basic_count", COUNT, 3);
        for (int i = 1; i <= 3; i++) begin
            rd(16'(i));
            step();
            chk("rout_one_cycle", R_OUT, 0);
        end
        chk("basic_empty", EMPTY, 1);
        chk("basic_count_end", COUNT, 0);

        // Fill, overflow with CLR in the same cycle (set wins), drain, then clear
        for (int i = 0; i < 16; i++) wr(16'(i));
        chk("fill_full", FULL, 1);
        chk("fill_count", COUNT, 16);
        chk("fill_ovf", OVF, 0);
        R_IN = 1'b1; D_IN = 16'd16; CLR = 1'b1;
        step();
        R_IN = 1'b0; CLR = 1'b0;
        chk("drop_ovf", OVF, 1);
        chk("drop_count", COUNT, 16);
        chk_ck("drop_cksum");
        for (int i = 0; i < 16; i++) rd(16'(i));
        step();
        chk("drain_empty", EMPTY, 1);
        chk("ovf_sticky", OVF, 1);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("clr_ovf", OVF, 0);

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) wr(16'h0100 + 16'(i));
        R_IN = 1'b1; D_IN = 16'hBEEF; RD = 1'b1;
        exp_q.push_back(16'h0100);
        cksum_m = cksum_m + 16'hBEEF;
        step();
        R_IN = 1'b0; RD = 1'b0;
        chk("rw_full_count", COUNT, 16);
        chk("rw_full_flag", FULL, 1);
        chk("rw_full_ovf", OVF, 0);
        for (int i = 1; i < 16; i++) rd(16'h0100 + 16'(i));
        rd(16'hBEEF);
        step();
        chk("rw_empty", EMPTY, 1);

        // Read on empty while a write lands
        R_IN = 1'b1; D_IN = 16'h00AA; RD = 1'b1;
        cksum_m = cksum_m + 16'h00AA;
        step();
        R_IN = 1'b0; RD = 1'b0;
        chk("empty_rd_rout", R_OUT, 0);
        chk("empty_rd_dout", D_OUT, 16'hBEEF);
        chk("empty_rd_count", COUNT, 1);
        chk_ck("cksum_run");
        rd(16'h00AA);
        step();

        // Asynchronous reset mid-operation with a read in flight
        for (int i = 0; i < 5; i++) wr(16'h0200 + 16'(i));
        rd(16'h0200);
        #1;
        RST = 1'b1;
        #1;
        exp_q.delete();
        chk("arst_empty", EMPTY, 1);
        chk("arst_count", COUNT, 0);
        chk("arst_rout", R_OUT, 0);
        chk("arst_dout", D_OUT, 0);
        chk("arst_cksum", CKSUM, 0);
        cksum_m = '0;
        step();
        step();
        RST = 1'b0;
        wr(16'h0300);
        chk("first_write", COUNT, 1);

        // EN=0 holds everything
        EN = 1'b0; R_IN = 1'b1; D_IN = 16'h1234; RD = 1'b1; CLR = 1'b1;
        repeat (3) step();
        chk("hold_count", COUNT, 1);
        chk("hold_empty", EMPTY, 0);
        chk("hold_rout", R_OUT, 0);
        chk("hold_dout", D_OUT, 0);
        chk_ck("hold_cksum");
        EN = 1'b1; R_IN = 1'b0; RD = 1'b0; CLR = 1'b0;
        rd(16'h0300);
        step();

        // Checksum wrap
        RST = 1'b1;
        step();
        RST = 1'b0;
        cksum_m = '0;
        wr(16'hFFFF);
        wr(16'h0002);
        chk("cksum_wrap", CKSUM, CK_ON ? 16'h0001 : 16'h0000);
        chk("cksum_count", COUNT, 2);

        step();
        step();
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
